// File: rtl/oled_spi_master.sv
// rtl/oled_spi_master.sv - AVR-style SPI master (SPCR/SPSR/SPDR) whose sck/mosi feed the OLED capture stage.
// All timing advances on the CPU clock enable.
module oled_spi_master (
  input  logic       clock,
  input  logic       reset,
  input  logic       ce,
  input  logic [1:0] addr,
  input  logic       wr,
  input  logic       rd,
  input  logic [7:0] din,
  output logic [7:0] dout,
  input  logic       miso,
  output logic       sck,
  output logic       mosi,
  output logic       irq,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, LEAD = 2'd1, TRAIL = 2'd2} state_t;
  state_t state, state_n;

  logic [7:0] spcr, shift, rx, shifted;
  logic       spif, wcol, spi2x, armed;
  logic [6:0] cnt, half, half_sel;
  logic [2:0] bit_cnt;
  logic       cpol_s, cpha_s, dord_s, sample;
  logic       sel_spsr, sel_spdr, wr_spcr, wr_spdr;
  logic       start, abort, phase_end, done, clear, spe_n, mstr_n, in_bit;

  function automatic logic out_bit(input logic [7:0] b, input logic lsb_first);
    return lsb_first ? b[0] : b[7];
  endfunction

  always_comb begin
    sel_spsr = ce && (addr == 2'd1);
    sel_spdr = ce && (addr == 2'd2);
    wr_spcr  = ce && wr && (addr == 2'd0);
    wr_spdr  = sel_spdr && wr;
    // An SPCR write dropping SPE or MSTR aborts on the very cycle it lands
    spe_n    = wr_spcr ? din[6] : spcr[6];
    mstr_n   = wr_spcr ? din[4] : spcr[4];
    case (spcr[1:0])
      2'd0:    half_sel = 7'd2;
      2'd1:    half_sel = 7'd8;
      2'd2:    half_sel = 7'd32;
      default: half_sel = 7'd64;
    endcase
    if (spi2x) half_sel = half_sel >> 1;
    start     = wr_spdr && (state == IDLE) && spcr[6] && spcr[4];
    phase_end = ce && (state != IDLE) && (cnt == half - 7'd1);
    abort     = ce && (state != IDLE) && !(spe_n && mstr_n);
    done      = phase_end && (state == TRAIL) && (bit_cnt == 3'd7) && !abort;
    clear     = armed && sel_spdr && (rd || wr);
    in_bit    = cpha_s ? miso : sample;
    shifted   = dord_s ? {in_bit, shift[7:1]} : {shift[6:0], in_bit};
    state_n   = state;
    case (state)
      IDLE:    if (start) state_n = LEAD;
      LEAD:    if (phase_end) state_n = TRAIL;
      TRAIL:   if (phase_end) state_n = (bit_cnt == 3'd7) ? IDLE : LEAD;
      default: state_n = IDLE;
    endcase
    if (abort) state_n = IDLE;
  end

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      spcr    <= 8'd0;
      spi2x   <= 1'b0;
      spif    <= 1'b0;
      wcol    <= 1'b0;
      armed   <= 1'b0;
      shift   <= 8'd0;
      rx      <= 8'd0;
      mosi    <= 1'b0;
      cnt     <= 7'd0;
      half    <= 7'd0;
      bit_cnt <= 3'd0;
      cpol_s  <= 1'b0;
      cpha_s  <= 1'b0;
      dord_s  <= 1'b0;
      sample  <= 1'b0;
    end else begin
      if (wr_spcr) spcr <= din;
      if (sel_spsr && wr) spi2x <= din[0];
      if (start) begin
        // Mode and rate are frozen for the whole byte
        shift   <= din;
        half    <= half_sel;
        cpol_s  <= spcr[3];
        cpha_s  <= spcr[2];
        dord_s  <= spcr[5];
        cnt     <= 7'd0;
        bit_cnt <= 3'd0;
        if (!spcr[2]) mosi <= out_bit(din, spcr[5]);
      end else if (abort) begin
        cnt <= 7'd0;
      end else if (ce && (state != IDLE)) begin
        cnt <= phase_end ? 7'd0 : cnt + 7'd1;
        if (phase_end && (state == LEAD)) begin
          if (cpha_s) mosi   <= out_bit(shift, dord_s);
          else        sample <= miso;
        end
        if (phase_end && (state == TRAIL)) begin
          shift   <= shifted;
          bit_cnt <= bit_cnt + 3'd1;
          if (!cpha_s && (bit_cnt != 3'd7)) mosi <= out_bit(shifted, dord_s);
          if (bit_cnt == 3'd7) rx <= shifted;
        end
      end
      if (done)       spif <= 1'b1;
      else if (clear) spif <= 1'b0;
      if (wr_spdr && (state != IDLE)) wcol <= 1'b1;
      else if (clear)                 wcol <= 1'b0;
      if (clear)                          armed <= 1'b0;
      else if (sel_spsr && rd && spif)    armed <= 1'b1;
    end
  end

  assign sck  = (state == IDLE) ? spcr[3] : (cpol_s ^ (state == TRAIL));
  assign busy = (state != IDLE);
  assign irq  = spcr[7] & spif;

  always_comb begin
    case (addr)
      2'd0:    dout = spcr;
      2'd1:    dout = {spif, wcol, 5'd0, spi2x};
      2'd2:    dout = rx;
      default: dout = 8'd0;
    endcase
  end

endmodule
